vx_alu_req_arb: RTL and testbench
=================================

// Module: vx_alu_req_arb
// PURPOSE
//  Round-robin arbiter sharing one ALU execute port among NUM_REQS issue sources.
//  Each source presents a packed ALU request payload with valid/ready.
//  Sits between the per-slice issue stage and the single ALU slave port.
//  One registered output stage: arbitration and payload are cut from the ALU side.
// PARAMETERS
//  NUM_REQS    4                    requester count, >=1; 1 = pure pipe register
//  REQ_BITS    vx_alu_pkg::REQ_BITS payload width = sum of all ALU request fields
//  SEL_BITS    $clog2(NUM_REQS)     grant index width (forced to 1 when NUM_REQS==1)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  reset      in   1                   asynchronous, active-low reset
//  req_valid  in   NUM_REQS            per-source request valid
//  req_data   in   NUM_REQS*REQ_BITS   per-source payload, source i at [i*REQ_BITS +: REQ_BITS]
//  req_ready  out  NUM_REQS            per-source accept; one-hot or zero
//  out_valid  out  1                   registered request to ALU valid
//  out_data   out  REQ_BITS            registered payload
//  out_sel    out  SEL_BITS            index of source that owns out_data
//  out_ready  in   1                   ALU accepts out_data this cycle
//  busy       out  1                   out_valid | (|req_valid)
// BEHAVIOUR
//  Reset (reset==0, async assert, sync deassert): out_valid=0, out_data=0, out_sel=0,
//   rr_ptr=0, req_ready=0; busy follows inputs combinationally.
//  Stage load enable: ld = ~out_valid | out_ready (accept new while draining old).
//  Arbitration (combinational): winner = first i with req_valid[i] scanning
//   rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQS.
//  req_ready[winner] = ld & (|req_valid); all other req_ready bits 0.
//  Transfer on source i when req_valid[i] & req_ready[i]; same edge:
//   out_data<=req_data[winner], out_sel<=winner, out_valid<=1, rr_ptr<=winner+1 (wrap).
//  ld & no valid source: out_valid<=0, out_data/out_sel hold, rr_ptr holds.
//  ~ld (out_valid & ~out_ready): all registers hold, req_ready=0.
//  Latency: 1 cycle accept->out_valid; sustained throughput 1 req/cycle.
//  Fairness: a continuously-valid source waits at most NUM_REQS-1 grants.
//  req_ready never depends on req_valid of the same source beyond winner selection;
//   sources must hold valid and payload stable until accepted (Vortex handshake).
//  Simultaneous out_ready and new accept: old payload leaves, new one loads, no bubble.
//  rr_ptr wrap: winner==NUM_REQS-1 -> rr_ptr<=0; NUM_REQS not a power of 2 supported.
//  Reset mid-transfer: in-flight out_data dropped, out_valid=0 immediately (async).
//  No payload field is interpreted; tid/tmask/is_max pass through bit-exact.
// STRUCTURE
//  vx_alu_pkg: typedef struct packed alu_req_t {uuid,wid,tmask,PC,next_PC,op_type,
//   op_mod,use_PC,use_imm,imm,tid,rs1_data,rs2_data,rd,wb,is_max};
//   localparam REQ_BITS=$bits(alu_req_t); pack/unpack helpers to/from VX_alu_req_if.
//  Sub-module vx_rr_pick (NUM_REQS): combinational rotate-priority picker,
//   inputs valid+ptr, outputs one-hot grant, index, any. Top holds registers only.
// TESTING
//  1 Reset: assert reset=0 mid-stream with out_valid=1 -> out_valid=0, req_ready=0
//    same cycle; after release first grant goes to source 0.
//  2 All 4 valid, out_ready=1 constant -> grants 0,1,2,3,0 on successive cycles,
//    out_sel matches 1 cycle later, out_data equals that source's payload.
//  3 Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_sel stable,
//    req_ready=0 throughout; out_ready=1 -> next grant same cycle, no bubble.
//  4 Sparse: only source 2 valid, rr_ptr=3 -> wraps to grant 2, rr_ptr becomes 3.
//  5 Single source valid every cycle, out_ready=1 -> 1 accept/cycle, out_valid stays 1.
//  6 NUM_REQS=3 and NUM_REQS=1 builds: wrap 2->0 correct; N=1 acts as pipe register.

Source files
------------

// File: rtl/vx_alu_pkg.sv
// Package for the ALU request arbiter.
// Defines the packed ALU request payload, its total width (REQ_BITS), and
// helpers to convert between the structured and flat forms of that payload.
package vx_alu_pkg;

    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int NW_BITS     = 2;
    localparam int UUID_BITS   = 44;
    localparam int TID_BITS    = 2;

    typedef struct packed {
        logic [UUID_BITS-1:0]                  uuid;
        logic [NW_BITS-1:0]                    wid;
        logic [NUM_THREADS-1:0]                tmask;
        logic [XLEN-1:0]                       PC;
        logic [XLEN-1:0]                       next_PC;
        logic [3:0]                            op_type;
        logic [2:0]                            op_mod;
        logic                                  use_PC;
        logic                                  use_imm;
        logic [XLEN-1:0]                       imm;
        logic [TID_BITS-1:0]                   tid;
        logic [NUM_THREADS-1:0][XLEN-1:0]      rs1_data;
        logic [NUM_THREADS-1:0][XLEN-1:0]      rs2_data;
        logic [4:0]                            rd;
        logic                                  wb;
        logic                                  is_max;
    } alu_req_t;

    localparam int REQ_BITS = $bits(alu_req_t);

    function automatic logic [REQ_BITS-1:0] alu_req_pack(input alu_req_t r);
        return r;
    endfunction

    function automatic alu_req_t alu_req_unpack(input logic [REQ_BITS-1:0] v);
        return alu_req_t'(v);
    endfunction

endpackage

// File: rtl/vx_alu_req_arb_pick.sv
// Combinational rotate-priority picker.
// Scans valid starting at ptr, wrapping modulo NUM_REQS, and reports the first
// set position.
//   valid : per-source request valid
//   ptr   : starting index of the scan (always < NUM_REQS)
//   grant : one-hot of the winner, zero when nothing is valid
//   idx   : index of the winner, zero when nothing is valid
//   any   : at least one source valid
module vx_rr_pick #(
    parameter int NUM_REQS = 4,
    parameter int SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic [NUM_REQS-1:0] valid,
    input  logic [SEL_BITS-1:0] ptr,
    output logic [NUM_REQS-1:0] grant,
    output logic [SEL_BITS-1:0] idx,
    output logic                any
);

    always_comb begin
        int unsigned j;
        j     = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            j = (32'(ptr) + k) % NUM_REQS;
            if (!any && valid[j]) begin
                grant[j] = 1'b1;
                idx      = SEL_BITS'(j);
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_alu_req_arb.sv
// Round-robin arbiter sharing one ALU execute port among NUM_REQS sources,
// with one registered output stage.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   req_valid : per-source request valid
//   req_data  : per-source payload, source i at [i*REQ_BITS +: REQ_BITS]
//   req_ready : per-source accept, one-hot or zero
//   out_valid : registered request valid towards the ALU
//   out_data  : registered payload
//   out_sel   : index of the source that owns out_data
//   out_ready : ALU accepts out_data this cycle
//   busy      : output stage occupied or any request pending
module vx_alu_req_arb
    import vx_alu_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int REQ_BITS = vx_alu_pkg::REQ_BITS,
    parameter int SEL_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*REQ_BITS-1:0] req_data,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         out_valid,
    output logic [REQ_BITS-1:0]          out_data,
    output logic [SEL_BITS-1:0]          out_sel,
    input  logic                         out_ready,
    output logic                         busy
);

    logic [SEL_BITS-1:0] rr_ptr;
    logic [NUM_REQS-1:0] grant;
    logic [SEL_BITS-1:0] win_idx;
    logic                win_any;
    logic                ld;
    logic [REQ_BITS-1:0] win_data;
    logic [SEL_BITS-1:0] ptr_next;

    vx_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .SEL_BITS (SEL_BITS)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Stage can load when empty or when its current content leaves this cycle.
    assign ld   = ~out_valid | out_ready;
    assign busy = out_valid | (|req_valid);

    // Reset gates ready so no source sees an accept while the stage is held clear.
    always_comb begin
        req_ready = '0;
        if (reset && ld) begin
            req_ready = grant;
        end
    end

    // One-hot AND-OR payload mux driven by the grant vector.
    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                win_data = win_data | req_data[i*REQ_BITS +: REQ_BITS];
            end
        end
    end

    always_comb begin
        ptr_next = win_idx + 1'b1;
        if (win_idx == SEL_BITS'(NUM_REQS - 1)) begin
            ptr_next = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            rr_ptr    <= '0;
        end else if (ld) begin
            if (win_any) begin
                out_valid <= 1'b1;
                out_data  <= win_data;
                out_sel   <= win_idx;
                rr_ptr    <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vx_alu_req_arb.sv
module tb_vx_alu_req_arb;
    import vx_alu_pkg::*;

    localparam int W = 512;

    logic clk;
    logic reset;

    // 4-source instance
    logic [3:0]            req_valid;
    logic [4*REQ_BITS-1:0] req_data;
    logic [3:0]            req_ready;
    logic                  out_valid;
    logic [REQ_BITS-1:0]   out_data;
    logic [1:0]            out_sel;
    logic                  out_ready;
    logic                  busy;

    // 3-source instance
    logic [2:0]            req_valid3;
    logic [3*REQ_BITS-1:0] req_data3;
    logic [2:0]            req_ready3;
    logic                  out_valid3;
    logic [REQ_BITS-1:0]   out_data3;
    logic [1:0]            out_sel3;
    logic                  out_ready3;
    logic                  busy3;

    // 1-source instance
    logic                  req_valid1;
    logic [REQ_BITS-1:0]   req_data1;
    logic                  req_ready1;
    logic                  out_valid1;
    logic [REQ_BITS-1:0]   out_data1;
    logic                  out_sel1;
    logic                  out_ready1;
    logic                  busy1;

    int unsigned n_tests;
    int unsigned n_fail;

    vx_alu_req_arb #(.NUM_REQS(4), .REQ_BITS(REQ_BITS)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sel(out_sel), .out_ready(out_ready), .busy(busy)
    );

    vx_alu_req_arb #(.NUM_REQS(3), .REQ_BITS(REQ_BITS)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_data(req_data3),
        .req_ready(req_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_sel(out_sel3), .out_ready(out_ready3), .busy(busy3)
    );

    vx_alu_req_arb #(.NUM_REQS(1), .REQ_BITS(REQ_BITS)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid1), .req_data(req_data1),
        .req_ready(req_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_sel(out_sel1), .out_ready(out_ready1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Distinct payload per (source, tag) touching the pass-through fields.
    function automatic logic [REQ_BITS-1:0] mk(input int unsigned src, input int unsigned tag);
        alu_req_t r;
        r          = '0;
        r.uuid     = 44'(tag * 16 + src);
        r.wid      = 2'(src);
        r.tmask    = 4'hF ^ 4'(src);
        r.PC       = 32'h8000_0000 + 32'(tag << 8) + 32'(src << 2);
        r.next_PC  = r.PC + 32'd4;
        r.imm      = 32'(tag * 1000 + src);
        r.tid      = 2'(src);
        r.rs1_data = {4{32'hA5A5_0000 | 32'(tag << 4) | 32'(src)}};
        r.rs2_data = ~r.rs1_data;
        r.rd       = 5'(src + tag);
        r.is_max   = 1'(tag & 1);
        return alu_req_pack(r);
    endfunction

    task automatic set4(input int unsigned src, input int unsigned tag);
        req_data[src*REQ_BITS +: REQ_BITS] = mk(src, tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b0;
        req_valid  = 4'hF;
        out_ready  = 1'b1;
        req_data   = '0;
        for (int unsigned s = 0; s < 4; s++) set4(s, 0);
        req_valid3 = '0;
        req_data3  = '0;
        out_ready3 = 1'b1;
        req_valid1 = 1'b0;
        req_data1  = '0;
        out_ready1 = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_sel",   W'(out_sel),   W'(0));
        check("rst_out_data",  W'(out_data),  W'(0));
        check("rst_req_ready", W'(req_ready), W'(0));
        check("rst_busy",      W'(busy),      W'(1));
        step();
        reset = 1'b1;

        // All four valid, out_ready held: grants 0,1,2,3,0
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rr_ready", W'(req_ready), W'(4'b0001 << (k % 4)));
            if (k > 0) begin
                check("rr_out_valid", W'(out_valid), W'(1));
                check("rr_out_sel",   W'(out_sel),   W'((k - 1) % 4));
                check("rr_out_data",  W'(out_data),  W'(mk((k - 1) % 4, 0)));
            end
            step();
        end

        // Backpressure: stage holds src0, rr_ptr=1
        out_ready = 1'b0;
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_ready",     W'(req_ready), W'(0));
            check("bp_out_valid", W'(out_valid), W'(1));
            check("bp_out_sel",   W'(out_sel),   W'(0));
            check("bp_out_data",  W'(out_data),  W'(mk(0, 0)));
            step();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", W'(req_ready), W'(4'b0010));
        check("bp_release_sel",   W'(out_sel),   W'(0));
        step();
        @(negedge clk);
        check("bp_next_sel",   W'(out_sel),   W'(1));
        check("bp_next_valid", W'(out_valid), W'(1));
        check("bp_next_data",  W'(out_data),  W'(mk(1, 0)));
        check("pre_sparse_ready", W'(req_ready), W'(4'b0100));
        step();

        // Sparse: rr_ptr=3, only source 2 valid -> wraps to 2
        req_valid = 4'b0100;
        set4(2, 1);
        @(negedge clk);
        check("sparse_ready", W'(req_ready), W'(4'b0100));
        step();
        req_valid = 4'b0000;
        @(negedge clk);
        check("sparse_out_sel",  W'(out_sel),   W'(2));
        check("sparse_out_data", W'(out_data),  W'(mk(2, 1)));
        check("sparse_busy",     W'(busy),      W'(1));
        check("idle_ready",      W'(req_ready), W'(0));
        step();
        @(negedge clk);
        check("idle_out_valid", W'(out_valid), W'(0));
        check("idle_busy",      W'(busy),      W'(0));
        check("idle_hold_sel",  W'(out_sel),   W'(2));
        req_valid = 4'hF;
        #1;
        check("ptr_after_sparse", W'(req_ready), W'(4'b1000));
        step();

        // Single source every cycle
        for (int unsigned t = 0; t < 4; t++) begin
            req_valid = 4'b0001;
            set4(0, t + 2);
            @(negedge clk);
            check("single_ready",     W'(req_ready), W'(4'b0001));
            check("single_out_valid", W'(out_valid), W'(1));
            if (t > 0) begin
                check("single_out_sel",  W'(out_sel),  W'(0));
                check("single_out_data", W'(out_data), W'(mk(0, t + 1)));
            end else begin
                check("single_first_sel", W'(out_sel), W'(3));
            end
            step();
        end
        @(negedge clk);
        check("single_last_data", W'(out_data), W'(mk(0, 5)));
        step();

        // Reset mid-stream: out_valid=1 here
        check("pre_rst_valid", W'(out_valid), W'(1));
        reset = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_req_ready", W'(req_ready), W'(0));
        step();
        reset     = 1'b1;
        req_valid = 4'hF;
        @(negedge clk);
        check("post_rst_grant", W'(req_ready), W'(4'b0001));
        step();
        req_valid = 4'h0;

        // NUM_REQS=3 wrap and NUM_REQS=1 pipe register, run side by side
        req_valid3 = 3'b111;
        for (int unsigned s = 0; s < 3; s++) req_data3[s*REQ_BITS +: REQ_BITS] = mk(s, 7);
        for (int unsigned k = 0; k < 6; k++) begin
            case (k)
                0: begin req_valid1 = 1'b1; req_data1 = mk(0, 10); out_ready1 = 1'b1; end
                1: begin req_valid1 = 1'b1; req_data1 = mk(0, 11); out_ready1 = 1'b1; end
                2: begin req_valid1 = 1'b1; req_data1 = mk(0, 12); out_ready1 = 1'b0; end
                3: begin req_valid1 = 1'b1; req_data1 = mk(0, 12); out_ready1 = 1'b1; end
                default: begin req_valid1 = 1'b0; out_ready1 = 1'b1; end
            endcase
            @(negedge clk);
            check("n3_ready", W'(req_ready3), W'(3'b001 << (k % 3)));
            if (k > 0) begin
                check("n3_out_sel",  W'(out_sel3),  W'((k - 1) % 3));
                check("n3_out_data", W'(out_data3), W'(mk((k - 1) % 3, 7)));
            end
            case (k)
                0: check("n1_ready0", W'(req_ready1), W'(1));
                1: begin
                    check("n1_ready1", W'(req_ready1), W'(1));
                    check("n1_data1",  W'(out_data1),  W'(mk(0, 10)));
                end
                2: begin
                    check("n1_ready_bp", W'(req_ready1), W'(0));
                    check("n1_data_bp",  W'(out_data1),  W'(mk(0, 11)));
                end
                3: begin
                    check("n1_ready3", W'(req_ready1), W'(1));
                    check("n1_data3",  W'(out_data1),  W'(mk(0, 11)));
                end
                4: begin
                    check("n1_data4",  W'(out_data1),  W'(mk(0, 12)));
                    check("n1_valid4", W'(out_valid1), W'(1));
                    check("n1_sel4",   W'(out_sel1),   W'(0));
                end
                default: check("n1_drained", W'(out_valid1), W'(0));
            endcase
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
